// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures ALU result/destination and completes BRAM loads
// (align + extend). Optional misalignment flag enabled by defining MEM_WB_MISALIGN_EN.
module mem_wb_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MEMOP_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_en,
  input  logic [MEMOP_W-1:0]    mem_op,
  input  logic [DATA_W-1:0]     mem_out,
  input  logic [1:0]            mem_addr_lo,
  input  logic [REG_ADDR_W-1:0] dst_addr,
  input  logic                  gpr_we,
  input  logic [DATA_W-1:0]     bram_rd_data,
`ifdef MEM_WB_MISALIGN_EN
  output logic                  miss_align,
`endif
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dst_addr,
  output logic                  wb_gpr_we,
  output logic [DATA_W-1:0]     wb_out
);

  // Memory-op codes; SB has no writeback or alignment effect here and is issued as NOP.
  localparam logic [MEMOP_W-1:0] OP_NOP = MEMOP_W'(0);
  localparam logic [MEMOP_W-1:0] OP_LB  = MEMOP_W'(1);
  localparam logic [MEMOP_W-1:0] OP_LH  = MEMOP_W'(2);
  localparam logic [MEMOP_W-1:0] OP_LW  = MEMOP_W'(3);
  localparam logic [MEMOP_W-1:0] OP_LBU = MEMOP_W'(4);
  localparam logic [MEMOP_W-1:0] OP_LHU = MEMOP_W'(5);
  localparam logic [MEMOP_W-1:0] OP_SH  = MEMOP_W'(6);
  localparam logic [MEMOP_W-1:0] OP_SW  = MEMOP_W'(7);

  logic                  en_q,  en_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic                  we_q,  we_d;
  logic [MEMOP_W-1:0]    op_q,  op_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic                  mis_q, mis_d;
  logic [MEMOP_W-1:0]    op_in;
  logic                  mis_in;

  always_comb begin
    op_in  = mem_en ? mem_op : OP_NOP;
    mis_in = 1'b0;
`ifdef MEM_WB_MISALIGN_EN
    if ((op_in == OP_LW || op_in == OP_SW) && mem_addr_lo != 2'b00)
      mis_in = 1'b1;
    if ((op_in == OP_LH || op_in == OP_LHU || op_in == OP_SH) && mem_addr_lo[0])
      mis_in = 1'b1;
`endif

    en_d  = en_q;
    dst_d = dst_q;
    we_d  = we_q;
    op_d  = op_q;
    off_d = off_q;
    out_d = out_q;
    mis_d = mis_q;
    if (flush) begin
      en_d  = 1'b0;
      dst_d = '0;
      we_d  = 1'b0;
      op_d  = OP_NOP;
      off_d = '0;
      out_d = '0;
      mis_d = 1'b0;
    end else if (!stall) begin
      en_d  = mem_en;
      dst_d = dst_addr;
      we_d  = gpr_we & mem_en & ~mis_in;
      op_d  = op_in;
      off_d = mem_addr_lo;
      out_d = mem_out;
      mis_d = mis_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q  <= 1'b0;
      dst_q <= '0;
      we_q  <= 1'b0;
      op_q  <= OP_NOP;
      off_q <= '0;
      out_q <= '0;
      mis_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      dst_q <= dst_d;
      we_q  <= we_d;
      op_q  <= op_d;
      off_q <= off_d;
      out_q <= out_d;
      mis_q <= mis_d;
    end
  end

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = off_q[1] ? bram_rd_data[31:16] : bram_rd_data[15:0];
    case (off_q)
      2'd0:    byte_sel = bram_rd_data[7:0];
      2'd1:    byte_sel = bram_rd_data[15:8];
      2'd2:    byte_sel = bram_rd_data[23:16];
      default: byte_sel = bram_rd_data[31:24];
    endcase

    case (op_q)
      OP_LW:   wb_out = bram_rd_data;
      OP_LH:   wb_out = {{(DATA_W-16){half_sel[15]}}, half_sel};
      OP_LHU:  wb_out = {{(DATA_W-16){1'b0}}, half_sel};
      OP_LB:   wb_out = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  wb_out = {{(DATA_W-8){1'b0}}, byte_sel};
      default: wb_out = out_q;
    endcase
  end

  assign wb_en       = en_q;
  assign wb_dst_addr = dst_q;
  assign wb_gpr_we   = we_q;
`ifdef MEM_WB_MISALIGN_EN
  assign miss_align  = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Randomized self-checking bench for mem_wb_reg against a transaction-level model.
// Covers the MEM_WB_MISALIGN_EN variant when the macro is defined.
module tb_mem_wb_reg;

  localparam int unsigned NOP = 0, LB = 1, LH = 2, LW = 3, LBU = 4, LHU = 5, SH = 6, SW = 7;

  logic        clk = 1'b0;
  logic        reset, stall, flush, mem_en, gpr_we;
  logic [2:0]  mem_op;
  logic [31:0] mem_out, bram_rd_data;
  logic [1:0]  mem_addr_lo;
  logic [4:0]  dst_addr;
  logic        wb_en, wb_gpr_we;
  logic [4:0]  wb_dst_addr;
  logic [31:0] wb_out;
`ifdef MEM_WB_MISALIGN_EN
  logic        miss_align;
`endif

  always #5 clk = ~clk;

  mem_wb_reg #(.DATA_W(32), .REG_ADDR_W(5), .MEMOP_W(3)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem_en(mem_en),
    .mem_op(mem_op), .mem_out(mem_out), .mem_addr_lo(mem_addr_lo),
    .dst_addr(dst_addr), .gpr_we(gpr_we), .bram_rd_data(bram_rd_data),
`ifdef MEM_WB_MISALIGN_EN
    .miss_align(miss_align),
`endif
    .wb_en(wb_en), .wb_dst_addr(wb_dst_addr), .wb_gpr_we(wb_gpr_we), .wb_out(wb_out)
  );

  int n_vec = 0;
  int n_miss = 0;

  // Model of the captured transaction
  int unsigned e_en, e_dst, e_we, e_op, e_off, e_out, e_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned misaligned(int unsigned op, int unsigned off);
`ifdef MEM_WB_MISALIGN_EN
    if ((op == LW || op == SW) && off != 0) return 1;
    if ((op == LH || op == LHU || op == SH) && (off % 2) == 1) return 1;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] model_out(int unsigned op, int unsigned off,
                                             int unsigned out, logic [31:0] rd);
    int unsigned h, b;
    h = (rd >> (16 * (off / 2))) % 65536;
    b = (rd >> (8 * off)) % 256;
    case (op)
      LW:  return rd;
      LH:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU: return h;
      LB:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU: return b;
      default: return out;
    endcase
  endfunction

  // One clock: update model at the edge, apply BRAM data, compare away from the edge.
  task automatic step(input logic [31:0] rd);
    @(posedge clk);
    if (reset || flush) begin
      e_en = 0; e_dst = 0; e_we = 0; e_op = NOP; e_off = 0; e_out = 0; e_mis = 0;
    end else if (!stall) begin
      e_en  = mem_en;
      e_dst = dst_addr;
      e_op  = mem_en ? mem_op : NOP;
      e_off = mem_addr_lo;
      e_out = mem_out;
      e_mis = misaligned(e_op, e_off);
      e_we  = (gpr_we && mem_en && e_mis == 0) ? 1 : 0;
    end
    #1 bram_rd_data = rd;
    #1;
    check("wb_en", 32'(wb_en), e_en);
    check("wb_dst_addr", 32'(wb_dst_addr), e_dst);
    check("wb_gpr_we", 32'(wb_gpr_we), e_we);
    check("wb_out", wb_out, model_out(e_op, e_off, e_out, bram_rd_data));
`ifdef MEM_WB_MISALIGN_EN
    check("miss_align", 32'(miss_align), e_mis);
`endif
  endtask

  task automatic drive(input logic en, input int unsigned op, input logic [31:0] out,
                       input int unsigned off, input int unsigned dst, input logic we);
    mem_en = en; mem_op = 3'(op); mem_out = out; mem_addr_lo = 2'(off);
    dst_addr = 5'(dst); gpr_we = we;
  endtask

  initial begin
    logic [31:0] rd;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; bram_rd_data = '0;
    drive(1'b0, NOP, '0, 0, 0, 1'b0);
    step(32'h0); step(32'h0);
    reset = 1'b0;
    step(32'h0);
    check("reset_wb_out", wb_out, 32'h0);

    drive(1'b1, NOP, 32'h1234_5678, 0, 5, 1'b1);
    step(32'hAAAA_5555);
    check("nop_out", wb_out, 32'h1234_5678);
    check("nop_dst", 32'(wb_dst_addr), 32'd5);
    check("nop_we", 32'(wb_gpr_we), 32'd1);

    drive(1'b1, LB, 32'h0, 3, 7, 1'b1);
    step(32'h80AB_CDEF);
    check("lb_sext", wb_out, 32'hFFFF_FF80);
    drive(1'b1, LBU, 32'h0, 3, 7, 1'b1);
    step(32'h80AB_CDEF);
    check("lbu_zext", wb_out, 32'h0000_0080);
    drive(1'b1, LH, 32'h0, 2, 8, 1'b1);
    step(32'h8001_7FFF);
    check("lh_sext", wb_out, 32'hFFFF_8001);
    drive(1'b1, LHU, 32'h0, 0, 8, 1'b1);
    step(32'h8001_7FFF);
    check("lhu_zext", wb_out, 32'h0000_7FFF);

    drive(1'b1, LW, 32'h0, 0, 9, 1'b1);
    step(32'hDEAD_BEEF);
    drive(1'b1, NOP, 32'h5555_0000, 1, 3, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(32'hDEAD_BEEF);
      check("stall_out", wb_out, 32'hDEAD_BEEF);
      check("stall_dst", 32'(wb_dst_addr), 32'd9);
    end
    flush = 1'b1;
    step(32'hDEAD_BEEF);
    check("flush_en", 32'(wb_en), 32'd0);
    check("flush_we", 32'(wb_gpr_we), 32'd0);
    stall = 1'b0; flush = 1'b0;

`ifdef MEM_WB_MISALIGN_EN
    drive(1'b1, LW, 32'h0, 1, 4, 1'b1);
    step(32'h0102_0304);
    check("lw_mis_flag", 32'(miss_align), 32'd1);
    check("lw_mis_we", 32'(wb_gpr_we), 32'd0);
    drive(1'b1, LH, 32'h0, 2, 4, 1'b1);
    step(32'h0102_0304);
    check("lh_ok_flag", 32'(miss_align), 32'd0);
    check("lh_ok_we", 32'(wb_gpr_we), 32'd1);
`else
    drive(1'b1, LW, 32'h0, 2, 4, 1'b1);
    step(32'h0102_0304);
    check("lw_off2_word", wb_out, 32'h0102_0304);
`endif

    rd = 32'h0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 8);
      stall = ($urandom_range(0, 99) < 20);
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      if (!stall) rd = $urandom;
      step(rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
